// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub
//
// Digit-serial adder/subtractor. An accepted start captures both operands and
// the operation, then RUN consumes one DIGIT-bit slice per clock (LSB slice
// first) through a single DIGIT-bit adder with a registered carry. After
// N = WIDTH/DIGIT slices the block spends one cycle in DONE, where o_done
// pulses and the result outputs take their new values. A start seen in DONE
// launches the next operation with no idle cycle in between.
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_reset     synchronous active-high reset
//   i_start     start request, ignored while o_busy is high
//   i_sub       0: A+B, 1: A-B (computed as A + ~B + 1)
//   i_A, i_B    WIDTH-bit operands
//   o_busy      high while an operation is in RUN
//   o_done      one-cycle pulse, result outputs valid from this cycle
//   o_sum       result modulo 2^WIDTH
//   o_carry     carry out of the MSB (subtract: 1 = no borrow)
//   o_overflow  two's-complement signed overflow
//   o_zero      o_sum is all zeros
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, result outputs hold the last result
// RUN    | one digit slice added per cycle, o_busy high
// DONE   | result just registered, o_done high, start accepted here

module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT:0]   slice_full;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             msb_cin;
    logic [WIDTH-1:0] acc_next;
    logic             start_ok;

    // Operands sit in shift registers so the active slice is always the low
    // DIGIT bits; the partial result is filled from the top, so after N
    // slices acc holds the full sum in its natural bit order.
    always_comb begin
        slice_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
        slice_sum  = slice_full[DIGIT-1:0];
        slice_cout = slice_full[DIGIT];
        // Carry into the top bit of the slice, recovered from its sum bit;
        // only meaningful on the last slice, where it feeds overflow.
        msb_cin    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];
        acc_next   = (acc_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
        start_ok   = i_start && (state_q != S_RUN);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_cout;
                acc_d   = acc_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    sum_d   = acc_next;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cout ^ msb_cin;
                    zero_d  = (acc_next == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // start_ok excludes RUN, so this never collides with the slice update.
        if (start_ok) begin
            state_d = S_RUN;
            cnt_d   = '0;
            carry_d = i_sub;
            a_d     = i_A;
            b_d     = i_sub ? ~i_B : i_B;
            acc_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign o_busy     = (state_q == S_RUN);
    assign o_done     = (state_q == S_DONE);
    assign o_sum      = sum_q;
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;

endmodule
